// File: rtl/hilo_mdu_if.sv
// HI/LO unit pipeline interface: decoded EX-stage control in, HI/LO and stall out.
interface hilo_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             stall;
    logic             done;

    modport master (output start, op, a, b, flush, input hi, lo, stall, done);
    modport slave  (input start, op, a, b, flush, output hi, lo, stall, done);
endinterface

// File: rtl/hilo_mdu.sv
// Execute-stage HI/LO unit: iterative 32-step multiply/divide plus MTHI/MTLO,
// owning the architectural HI and LO registers.
module hilo_mdu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic       clk,
    input logic       rst_n,
    hilo_mdu_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 is_div_q, is_div_d, is_sgn_q, is_sgn_d;
    logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 stall_c;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [CNT_W-1:0]     div_idx;
    logic [WIDTH:0]       rem_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     rem_mag, quo_mag;

    assign rem_mag = acc_q[2*WIDTH-1:WIDTH];
    assign quo_mag = acc_q[WIDTH-1:0];

    // One iteration of each datapath: shift-add multiply, restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[cnt_q] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        // Dividend bits are consumed MSB first; WIDTH-1-cnt is ~cnt since WIDTH = 2^CNT_W.
        div_idx   = ~cnt_q;
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[div_idx]};
        div_diff  = rem_shift - {1'b0, b_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state, register updates and stall for the accept/prep/calc/commit sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        is_sgn_d  = is_sgn_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        stall_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d      = bus.a;
                            b_d      = bus.b;
                            is_div_d = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                            is_sgn_d = (bus.op == OP_MULT) || (bus.op == OP_DIV);
                            state_d  = S_PREP;
                            stall_c  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_PREP: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d       = (is_sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    b_d       = (is_sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    neg_res_d = is_sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_d = is_sgn_q && a_q[WIDTH-1];
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '1) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    // With a zero divisor the remainder path still leaves |a| in the
                    // upper half, so restoring the dividend sign yields hi = a.
                    hi_d = neg_rem_q ? -rem_mag : rem_mag;
                    if (b_q == '0) begin
                        lo_d = '1;
                    end else begin
                        lo_d = neg_res_q ? -quo_mag : quo_mag;
                    end
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears HI/LO and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            is_sgn_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            is_sgn_q  <= is_sgn_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
    assign bus.stall = stall_c && rst_n;
endmodule

// File: tb/tb_hilo_mdu.sv
// Directed table-driven bench for hilo_mdu plus hand-written flush/reset sequences.
module tb_hilo_mdu;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          fin_flush;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[12];

    hilo_mdu_if #(.WIDTH(32)) bus ();

    hilo_mdu #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one mul/div, scramble inputs while busy, then check stall length, done pulse and result.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        logic [2:0] dseq;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            bus.op = OP_DIVU;
            bus.a  = $urandom;
            bus.b  = $urandom;
        end
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        if (v.fin_flush) bus.flush = 1'b1;
        check({tag, "_stall_cycles"}, 64'(n), 64'd34);
        dseq[2] = bus.done;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        dseq[1] = bus.done;
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, v.hi});
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, v.lo});
        @(posedge clk);
        #1;
        dseq[0] = bus.done;
        check({tag, "_done_pulse"}, {61'd0, dseq}, 64'd2);
    endtask

    initial begin
        int dseen;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b1};
        vecs[4]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{OP_MULT,  32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

        // Reset with a pending MULT on the inputs: stall must stay low.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        bus.flush = 1'b0;
        #12;
        check("reset_stall", {63'd0, bus.stall}, 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = OP_NONE;
        rst_n     = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'hAAAA5555;
        #1;
        check("mthi_stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk);
        #1;
        check("mthi_hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h0FFFFFFF});
        bus.op = OP_MTLO;
        bus.a  = 32'h0F0F0F0F;
        #1;
        check("mtlo_stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk);
        #1;
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h0F0F0F0F});

        // Flush in IDLE blocks both MTHI and a mul/div accept.
        bus.op    = OP_MTHI;
        bus.a     = 32'h12345678;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("idle_flush_mthi", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h0F0F0F0F});
        bus.op = OP_MULT;
        #1;
        check("idle_flush_stall", {63'd0, bus.stall}, 64'd0);
        @(posedge clk);
        #1;
        check("idle_flush_no_accept", {63'd0, bus.stall}, 64'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = OP_NONE;

        // MULT flushed during CALC with counter == 10.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        #1;
        check("cflush_accept_stall", {63'd0, bus.stall}, 64'd1);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.op    = OP_NONE;
        end
        check("cflush_busy_stall", {63'd0, bus.stall}, 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("cflush_stall_drop", {63'd0, bus.stall}, 64'd0);
        check("cflush_hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h0F0F0F0F});
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dseen++;
        end
        check("cflush_no_done", 64'(dseen), 64'd0);

        // Reset asserted in the middle of CALC.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'h0000FFFF;
        bus.b     = 32'h0000FFFF;
        repeat (15) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.op    = OP_NONE;
        end
        check("mrst_busy_stall", {63'd0, bus.stall}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_stall", {63'd0, bus.stall}, 64'd0);
        check("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0}, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Execute-stage HI/LO unit of the 5-stage MIPS pipeline. It is driven by the decoded control for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the architectural HI and LO registers.
- Multiply and divide are iterative, 32 steps each. While one is running, a stall is raised so the hazard logic freezes IF/ID/EX.
- HI/LO outputs feed the MFHI/MFLO writeback mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (2^CNT_W = WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid HI/LO-class instruction.
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes behave as none.
- a  in  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- b  in  WIDTH  rt value (multiplier / divisor).
- flush  in  1  EX flush (exception/branch kill); aborts operation.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- stall  out  1  combinational; freeze pipeline.
- done  out  1  one-cycle pulse when a mul/div result is committed.

Behaviour:
- Reset (rst_n=0, async):
  - hi=0, lo=0, state=IDLE, counter=0, done=0.
  - stall=0 while reset is asserted.
- States: IDLE, PREP, CALC, FIN.
- IDLE:
  - start & op∈{MTHI,MTLO}: hi (or lo) <= a at the clock edge. Single cycle, no stall, state stays IDLE. The other register is unchanged.
  - start & op∈{MULT..DIVU}: latch a, b, op; go to PREP; stall=1 in this cycle.
  - Otherwise remain in IDLE.
- PREP (1 cycle):
  - Signed ops: take magnitudes of a and b and record result sign and remainder sign (dividend sign).
  - Clear the 2*WIDTH accumulator and set counter=0.
  - stall=1.
- CALC (exactly 32 cycles, counter 0..31):
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring; one quotient bit per cycle.
  - stall=1. Leave to FIN when counter==31.
- FIN (1 cycle):
  - stall=0, so the instruction leaves EX at this edge.
  - At the edge, {hi,lo} <= signed-corrected product, or hi<=remainder, lo<=quotient. done=1.
  - start/op are ignored in FIN (they still belong to the retiring instruction). Next state IDLE.
- Latency: stall is high for 34 consecutive cycles (accept cycle + PREP + 32 CALC). HI/LO are visible the cycle after FIN.
- Stall equation: (IDLE & start & op∈mul/div & ~flush) | PREP | CALC.
- Signed fix-up:
  - Product negated if the operand signs differ.
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend sign.
- Divide by zero (b=0, any div op): lo=0xFFFFFFFF, hi=a. No sign fix. Still 34 stall cycles. No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- MULT of most-negative operands: the full 64-bit result is exact (0x80000000*0x80000000 = 0x4000000000000000).
- flush:
  - Any state except FIN: return to IDLE next edge; hi/lo unchanged; done=0.
  - In IDLE, flush suppresses acceptance, including MTHI/MTLO writes.
  - In FIN, the commit proceeds.
- Reset mid-operation: immediate return to IDLE with hi=lo=0.
- start/op/a/b changes while busy are ignored; operands are latched at accept.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> stall high 34 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xAAAA5555 then MTLO a=0x0F0F0F0F on consecutive cycles -> no stall; hi and lo update one edge after each; other register untouched.
- MULT started, flush at CALC counter=10 -> stall drops next cycle; hi/lo retain prior values; no done. Separately, rst_n low mid-CALC -> hi=lo=0, stall=0 immediately.
